acc_frame_ctrl: RTL

Initiator-side controller that drives the accumulator's en_i/clear_i/data_i interface and reads back its result_o. It accepts a valid/ready sample stream and groups it into frames of FRAME_LEN samples. Before each frame it clears the accumulator, then feeds the samples in, captures the final result and presents it on a valid/ready result port. An internal shadow sum cross-checks the accumulator result per frame.

---
 rtl/acc_frame_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/acc_frame_ctrl.sv
// Initiator-side frame controller for a clear/enable accumulator: groups a sample
// stream into frames, drives the accumulator and returns each frame result with a shadow-sum check.
module acc_frame_ctrl #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 32,
  parameter int FRAME_LEN  = 8,
  parameter int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DIN_WIDTH-1:0]  s_data_i,
  input  logic                  flush_i,
  output logic                  acc_en_o,
  output logic                  acc_clear_o,
  output logic [DIN_WIDTH-1:0]  acc_data_o,
  input  logic [DOUT_WIDTH-1:0] acc_result_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DOUT_WIDTH-1:0] m_sum_o,
  output logic [CNT_WIDTH-1:0]  m_count_o,
  output logic                  m_err_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CAPT  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_LEN - 1);

  state_t                  state_r;
  logic [CNT_WIDTH-1:0]    count_r;
  logic [DOUT_WIDTH-1:0]   shadow_r;
  logic                    acc_en_r;
  logic                    acc_clear_r;
  logic [DIN_WIDTH-1:0]    acc_data_r;
  logic                    m_valid_r;
  logic [DOUT_WIDTH-1:0]   m_sum_r;
  logic [CNT_WIDTH-1:0]    m_count_r;
  logic                    m_err_r;

  logic                    accum_s;
  logic                    s_hs_s;
  logic                    close_s;

  // Sign-extend a sample to the accumulator width, matching the accumulator's own add.
  function automatic logic [DOUT_WIDTH-1:0] sext(input logic [DIN_WIDTH-1:0] d);
    return DOUT_WIDTH'($signed(d));
  endfunction

  assign accum_s = (state_r == ST_ACCUM);
  assign s_hs_s  = accum_s && s_valid_i;
  // A frame closes on its last beat or on a flush; a same-cycle beat is still counted.
  assign close_s = flush_i || (s_hs_s && (count_r == CNT_LAST));

  // Frame sequencing FSM with all accumulator- and result-side outputs registered.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      acc_en_r    <= 1'b0;
      acc_clear_r <= 1'b0;
      acc_data_r  <= '0;
      m_valid_r   <= 1'b0;
      m_sum_r     <= '0;
      m_count_r   <= '0;
      m_err_r     <= 1'b0;
    end else begin
      acc_en_r    <= 1'b0;
      acc_clear_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          acc_clear_r <= 1'b1;
          state_r     <= ST_CLEAR;
        end
        ST_CLEAR: begin
          state_r <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (s_hs_s) begin
            acc_en_r   <= 1'b1;
            acc_data_r <= s_data_i;
          end
          if (close_s) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_r <= ST_CAPT;
        end
        ST_CAPT: begin
          m_sum_r   <= acc_result_i;
          m_count_r <= count_r;
          m_err_r   <= (acc_result_i != shadow_r);
          m_valid_r <= 1'b1;
          state_r   <= ST_OUT;
        end
        ST_OUT: begin
          if (m_ready_i) begin
            m_valid_r   <= 1'b0;
            acc_clear_r <= 1'b1;
            state_r     <= ST_CLEAR;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Beat counter and shadow sum, restarted alongside each accumulator clear.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r  <= '0;
      shadow_r <= '0;
    end else if (state_r == ST_CLEAR) begin
      count_r  <= '0;
      shadow_r <= '0;
    end else if (s_hs_s) begin
      count_r  <= count_r + CNT_ONE;
      shadow_r <= shadow_r + sext(s_data_i);
    end
  end

  assign s_ready_o   = accum_s;
  assign busy_o      = (state_r != ST_IDLE);
  assign acc_en_o    = acc_en_r;
  assign acc_clear_o = acc_clear_r;
  assign acc_data_o  = acc_data_r;
  assign m_valid_o   = m_valid_r;
  assign m_sum_o     = m_sum_r;
  assign m_count_o   = m_count_r;
  assign m_err_o     = m_err_r;

endmodule
